// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access sizes, response error codes,
// FSM states and the lane helpers used when an access is accepted.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } lsu_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Any funct3 outside the five legal encodings behaves as a full word.
    function automatic lsu_size_e normalizeSize(input logic [2:0] raw);
        normalizeSize = SIZE_W;
        case (raw)
            3'b000:  normalizeSize = SIZE_B;
            3'b001:  normalizeSize = SIZE_H;
            3'b100:  normalizeSize = SIZE_BU;
            3'b101:  normalizeSize = SIZE_HU;
            default: normalizeSize = SIZE_W;
        endcase
    endfunction

    function automatic logic isMisaligned(input lsu_size_e size, input logic [1:0] addrLow);
        isMisaligned = 1'b0;
        case (size)
            SIZE_H, SIZE_HU: isMisaligned = addrLow[0];
            SIZE_W:          isMisaligned = (addrLow != 2'b00);
            default:         isMisaligned = 1'b0;
        endcase
    endfunction

    // Loads always fetch the whole word; stores enable only the lanes they write.
    function automatic logic [3:0] byteEnable(input logic store, input lsu_size_e size,
                                              input logic [1:0] addrLow);
        byteEnable = 4'b1111;
        if (store) begin
            case (size)
                SIZE_B, SIZE_BU: byteEnable = 4'b0001 << addrLow;
                SIZE_H, SIZE_HU: byteEnable = 4'b0011 << {addrLow[1], 1'b0};
                default:         byteEnable = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] replicateData(input lsu_size_e size, input logic [31:0] wdata);
        case (size)
            SIZE_B, SIZE_BU: replicateData = {4{wdata[7:0]}};
            SIZE_H, SIZE_HU: replicateData = {2{wdata[15:0]}};
            default:         replicateData = wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Handshake bundles of the load/store unit: the core-facing request/response
// channel and the memory-facing access channel.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_store, req_size, req_addr, req_wdata, req_rd, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
    );
    modport slave (
        input  req_valid, req_store, req_size, req_addr, req_wdata, req_rd, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte or half out of a raw memory word and sign- or
// zero-extends it according to the load size.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic [1:0]  i_addrLow,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_rdata;
        case (i_addrLow)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addrLow[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SIZE_B:  o_data = {{24{w_byte[7]}}, w_byte};
            SIZE_BU: o_data = {24'h000000, w_byte};
            SIZE_H:  o_data = {{16{w_half[15]}}, w_half};
            SIZE_HU: o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one core access, issues it to a
// word-wide memory, and returns an extended, tagged response or an error code.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic     clk,
    input  logic     reset,
    lsu_req_if.slave core,
    lsu_mem_if.master mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    lsu_size_e        r_size;
    logic             r_store;
    logic [1:0]       r_addrLow;
    logic [4:0]       r_rd;

    lsu_size_e        w_reqSize;
    logic             w_misaligned;
    logic [31:0]      w_loadData;

    assign w_reqSize    = normalizeSize(core.req_size);
    assign w_misaligned = isMisaligned(w_reqSize, core.req_addr[1:0]);

    lsu_load_align u_align (
        .i_size    (r_size),
        .i_addrLow (r_addrLow),
        .i_rdata   (mem.mem_rdata),
        .o_data    (w_loadData)
    );

    // All handshake outputs are registers, so they only change on a state transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_size         <= SIZE_B;
            r_store        <= 1'b0;
            r_addrLow      <= 2'b00;
            r_rd           <= 5'd0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= 32'h0;
            mem.mem_be     <= 4'h0;
            mem.mem_wdata  <= 32'h0;
            core.req_ready <= 1'b1;
            core.rsp_valid <= 1'b0;
            core.rsp_data  <= 32'h0;
            core.rsp_rd    <= 5'd0;
            core.rsp_err   <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (core.req_valid && core.req_ready) begin
                        r_size         <= w_reqSize;
                        r_store        <= core.req_store;
                        r_addrLow      <= core.req_addr[1:0];
                        r_rd           <= core.req_rd;
                        r_cnt          <= '0;
                        core.req_ready <= 1'b0;
                        // Misaligned accesses never reach memory.
                        if (w_misaligned) begin
                            r_state        <= ST_RESP;
                            core.rsp_valid <= 1'b1;
                            core.rsp_data  <= 32'h0;
                            core.rsp_rd    <= core.req_rd;
                            core.rsp_err   <= ERR_MISALIGN;
                        end else begin
                            r_state       <= ST_ISSUE;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= core.req_store;
                            mem.mem_addr  <= {core.req_addr[31:2], 2'b00};
                            mem.mem_be    <= byteEnable(core.req_store, w_reqSize, core.req_addr[1:0]);
                            mem.mem_wdata <= core.req_store ? replicateData(w_reqSize, core.req_wdata) : 32'h0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem.mem_gnt) begin
                        r_state       <= ST_WAIT;
                        r_cnt         <= '0;
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= 32'h0;
                        mem.mem_be    <= 4'h0;
                        mem.mem_wdata <= 32'h0;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid) begin
                        r_state        <= ST_RESP;
                        core.rsp_valid <= 1'b1;
                        core.rsp_data  <= r_store ? 32'h0 : w_loadData;
                        core.rsp_rd    <= r_rd;
                        core.rsp_err   <= ERR_OK;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state        <= ST_RESP;
                        core.rsp_valid <= 1'b1;
                        core.rsp_data  <= 32'h0;
                        core.rsp_rd    <= r_rd;
                        core.rsp_err   <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (core.rsp_ready) begin
                        r_state        <= ST_IDLE;
                        core.rsp_valid <= 1'b0;
                        core.rsp_data  <= 32'h0;
                        core.rsp_rd    <= 5'd0;
                        core.rsp_err   <= ERR_OK;
                        core.req_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned loads/stores, misalignment,
// timeout, backpressure and a reset taken in the middle of an access.
module tb_load_store_unit;

    typedef struct {
        logic        store;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expData;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vectors [11];

    lsu_req_if coreBus ();
    lsu_mem_if memBus ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (coreBus),
        .mem   (memBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic store, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd);
        coreBus.req_valid = 1'b1;
        coreBus.req_store = store;
        coreBus.req_size  = size;
        coreBus.req_addr  = addr;
        coreBus.req_wdata = wdata;
        coreBus.req_rd    = rd;
        step();
        coreBus.req_valid = 1'b0;
        coreBus.req_wdata = 32'h0;
    endtask

    // Full access with programmable grant and response-consume delays.
    task automatic doAccess(input vec_t v, input int idx, input int gntDelay, input int rspDelay);
        applyStimulus(v.store, v.size, v.addr, v.wdata, v.rd);
        for (int i = 0; i <= gntDelay; i++) begin
            checkOutput($sformatf("v%0d_c%0d_mem_req", idx, i), memBus.mem_req, 32'd1);
            checkOutput($sformatf("v%0d_c%0d_mem_addr", idx, i), memBus.mem_addr, v.expAddr);
            checkOutput($sformatf("v%0d_c%0d_mem_be", idx, i), memBus.mem_be, v.expBe);
            checkOutput($sformatf("v%0d_c%0d_mem_we", idx, i), memBus.mem_we, v.store);
            if (v.store) checkOutput($sformatf("v%0d_c%0d_mem_wdata", idx, i), memBus.mem_wdata, v.expWdata);
            checkOutput($sformatf("v%0d_c%0d_req_ready_issue", idx, i), coreBus.req_ready, 32'd0);
            if (i == gntDelay) memBus.mem_gnt = 1'b1;
            step();
        end
        memBus.mem_gnt = 1'b0;
        checkOutput($sformatf("v%0d_mem_req_wait", idx), memBus.mem_req, 32'd0);
        checkOutput($sformatf("v%0d_rsp_valid_wait", idx), coreBus.rsp_valid, 32'd0);
        memBus.mem_rvalid = 1'b1;
        memBus.mem_rdata  = v.rdata;
        step();
        memBus.mem_rvalid = 1'b0;
        memBus.mem_rdata  = 32'h5A5A5A5A;
        for (int i = 0; i <= rspDelay; i++) begin
            checkOutput($sformatf("v%0d_r%0d_rsp_valid", idx, i), coreBus.rsp_valid, 32'd1);
            checkOutput($sformatf("v%0d_r%0d_rsp_data", idx, i), coreBus.rsp_data, v.expData);
            checkOutput($sformatf("v%0d_r%0d_rsp_err", idx, i), coreBus.rsp_err, 32'd0);
            checkOutput($sformatf("v%0d_r%0d_rsp_rd", idx, i), coreBus.rsp_rd, v.rd);
            checkOutput($sformatf("v%0d_r%0d_req_ready_resp", idx, i), coreBus.req_ready, 32'd0);
            if (i == rspDelay) coreBus.rsp_ready = 1'b1;
            step();
        end
        coreBus.rsp_ready = 1'b0;
        checkOutput($sformatf("v%0d_rsp_valid_done", idx), coreBus.rsp_valid, 32'd0);
        checkOutput($sformatf("v%0d_req_ready_done", idx), coreBus.req_ready, 32'd1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mem_req"}, memBus.mem_req, 32'd0);
        checkOutput({tag, "_mem_we"}, memBus.mem_we, 32'd0);
        checkOutput({tag, "_mem_be"}, memBus.mem_be, 32'd0);
        checkOutput({tag, "_mem_addr"}, memBus.mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, memBus.mem_wdata, 32'd0);
        checkOutput({tag, "_rsp_valid"}, coreBus.rsp_valid, 32'd0);
        checkOutput({tag, "_rsp_data"}, coreBus.rsp_data, 32'd0);
        checkOutput({tag, "_rsp_rd"}, coreBus.rsp_rd, 32'd0);
        checkOutput({tag, "_rsp_err"}, coreBus.rsp_err, 32'd0);
        checkOutput({tag, "_req_ready"}, coreBus.req_ready, 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        // store, size, addr, wdata, rdata, rd, expAddr, expBe, expWdata, expData
        vectors[0]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 5'd5, 32'h100, 4'b1111, 32'h0, 32'hFFFFFF80};
        vectors[1]  = '{1'b1, 3'b001, 32'h022, 32'h0000BEEF, 32'h0, 5'd6, 32'h020, 4'b1100, 32'hBEEFBEEF, 32'h0};
        vectors[2]  = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h12348056, 5'd7, 32'h100, 4'b1111, 32'h0, 32'h00000080};
        vectors[3]  = '{1'b0, 3'b001, 32'h012, 32'h0, 32'h9ABC1234, 5'd8, 32'h010, 4'b1111, 32'h0, 32'hFFFF9ABC};
        vectors[4]  = '{1'b0, 3'b101, 32'h012, 32'h0, 32'h9ABC1234, 5'd9, 32'h010, 4'b1111, 32'h0, 32'h00009ABC};
        vectors[5]  = '{1'b0, 3'b010, 32'h040, 32'h0, 32'hDEADBEEF, 5'd10, 32'h040, 4'b1111, 32'h0, 32'hDEADBEEF};
        vectors[6]  = '{1'b1, 3'b000, 32'h007, 32'h123456A5, 32'h0, 5'd11, 32'h004, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vectors[7]  = '{1'b1, 3'b010, 32'h008, 32'hCAFEF00D, 32'h0, 5'd12, 32'h008, 4'b1111, 32'hCAFEF00D, 32'h0};
        vectors[8]  = '{1'b0, 3'b011, 32'h020, 32'h0, 32'h01020304, 5'd13, 32'h020, 4'b1111, 32'h0, 32'h01020304};
        vectors[9]  = '{1'b0, 3'b001, 32'h010, 32'h0, 32'hFFFF7FFF, 5'd14, 32'h010, 4'b1111, 32'h0, 32'h00007FFF};
        vectors[10] = '{1'b0, 3'b000, 32'h200, 32'h0, 32'hAAAAAA7F, 5'd15, 32'h200, 4'b1111, 32'h0, 32'h0000007F};

        reset             = 1'b0;
        coreBus.req_valid = 1'b0;
        coreBus.req_store = 1'b0;
        coreBus.req_size  = 3'b000;
        coreBus.req_addr  = 32'h0;
        coreBus.req_wdata = 32'h0;
        coreBus.req_rd    = 5'd0;
        coreBus.rsp_ready = 1'b0;
        memBus.mem_gnt    = 1'b0;
        memBus.mem_rvalid = 1'b0;
        memBus.mem_rdata  = 32'h0;

        step();
        step();
        checkIdleOutputs("in_reset");
        reset = 1'b1;
        step();
        checkIdleOutputs("after_reset");

        $display("[TB] aligned access vectors");
        for (int k = 0; k < 11; k++) doAccess(vectors[k], k, 0, 0);

        $display("[TB] backpressure: grant after 3 cycles, response consumed after 2");
        doAccess(vectors[3], 20, 3, 2);
        doAccess(vectors[1], 21, 3, 2);

        $display("[TB] misaligned accesses");
        applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, 5'd9);
        checkOutput("mis_lw_rsp_valid", coreBus.rsp_valid, 32'd1);
        checkOutput("mis_lw_rsp_err", coreBus.rsp_err, 32'd1);
        checkOutput("mis_lw_rsp_data", coreBus.rsp_data, 32'd0);
        checkOutput("mis_lw_rsp_rd", coreBus.rsp_rd, 32'd9);
        checkOutput("mis_lw_mem_req", memBus.mem_req, 32'd0);
        coreBus.rsp_ready = 1'b1;
        step();
        coreBus.rsp_ready = 1'b0;
        checkOutput("mis_lw_mem_req_after", memBus.mem_req, 32'd0);
        checkOutput("mis_lw_req_ready", coreBus.req_ready, 32'd1);
        applyStimulus(1'b1, 3'b001, 32'h23, 32'h1234, 5'd4);
        checkOutput("mis_sh_rsp_valid", coreBus.rsp_valid, 32'd1);
        checkOutput("mis_sh_rsp_err", coreBus.rsp_err, 32'd1);
        checkOutput("mis_sh_mem_req", memBus.mem_req, 32'd0);
        checkOutput("mis_sh_mem_we", memBus.mem_we, 32'd0);
        coreBus.rsp_ready = 1'b1;
        step();
        coreBus.rsp_ready = 1'b0;

        $display("[TB] timeout with late rvalid");
        applyStimulus(1'b0, 3'b010, 32'h50, 32'h0, 5'd3);
        memBus.mem_gnt = 1'b1;
        step();
        memBus.mem_gnt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("to_wait%0d_rsp_valid", i), coreBus.rsp_valid, 32'd0);
            step();
        end
        checkOutput("to_rsp_valid", coreBus.rsp_valid, 32'd1);
        checkOutput("to_rsp_err", coreBus.rsp_err, 32'd2);
        checkOutput("to_rsp_data", coreBus.rsp_data, 32'd0);
        checkOutput("to_rsp_rd", coreBus.rsp_rd, 32'd3);
        memBus.mem_rvalid = 1'b1;
        memBus.mem_rdata  = 32'hFFFFFFFF;
        step();
        memBus.mem_rvalid = 1'b0;
        checkOutput("to_late_rsp_valid", coreBus.rsp_valid, 32'd1);
        checkOutput("to_late_rsp_err", coreBus.rsp_err, 32'd2);
        checkOutput("to_late_rsp_data", coreBus.rsp_data, 32'd0);
        coreBus.rsp_ready = 1'b1;
        step();
        coreBus.rsp_ready = 1'b0;
        checkOutput("to_done_req_ready", coreBus.req_ready, 32'd1);
        doAccess(vectors[5], 30, 0, 0);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 3'b010, 32'h60, 32'h0, 5'd21);
        memBus.mem_gnt = 1'b1;
        step();
        memBus.mem_gnt = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        checkIdleOutputs("wait_reset");
        memBus.mem_rvalid = 1'b1;
        memBus.mem_rdata  = 32'h12345678;
        step();
        memBus.mem_rvalid = 1'b0;
        checkOutput("wait_reset_stray_rvalid", coreBus.rsp_valid, 32'd0);
        doAccess(vectors[0], 40, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
